// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind a UART receiver: stores {framing_err, data} per byte, show-ahead head register.
// Latency: a byte written into an empty FIFO appears on o_RD_DATA with o_RD_VALID=1 one cycle after its i_RX_DONE edge.
// Backpressure: none toward the receiver; a full FIFO drops the byte and sets sticky o_OVERFLOW unless a read frees a slot that cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_CLK,
  input  logic          i_RESET,
  input  logic          i_RX_DONE,
  input  logic [7:0]    i_RX_DATA,
  input  logic          i_FRAMING_ERROR,
  input  logic          i_DROP_ERRORED,
  input  logic          i_RD_READY,
  input  logic          i_CLR_FLAGS,
  output logic [7:0]    o_RD_DATA,
  output logic          o_RD_ERR,
  output logic          o_RD_VALID,
  output logic [CW-1:0] o_COUNT,
  output logic          o_EMPTY,
  output logic          o_FULL,
  output logic          o_OVERFLOW,
  output logic [7:0]    o_DROP_COUNT
);

  localparam int AW = $clog2(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [8:0]    wr_word;
  logic          wr_req;
  logic          wr_en;
  logic          rd_en;
  logic          drop_hit;
  logic          ovf_hit;

  // Occupancy flags are decoded from the registered count.
  assign o_EMPTY    = (o_COUNT == '0);
  assign o_FULL     = (o_COUNT == CW'(DEPTH));
  assign o_RD_VALID = ~o_EMPTY;

  // Accept/discard decisions for this cycle; a read at full makes room for a same-cycle write.
  always_comb begin
    wr_word    = {i_FRAMING_ERROR, i_RX_DATA};
    drop_hit   = i_RX_DONE & i_DROP_ERRORED & i_FRAMING_ERROR;
    wr_req     = i_RX_DONE & ~(i_DROP_ERRORED & i_FRAMING_ERROR);
    rd_en      = o_RD_VALID & i_RD_READY;
    wr_en      = wr_req & (~o_FULL | rd_en);
    ovf_hit    = wr_req & o_FULL & ~rd_en;
    rd_ptr_nxt = rd_ptr + AW'(1);
  end

  // Storage array; no reset needed because the pointers define what is valid.
  always_ff @(posedge i_CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_COUNT <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr_nxt;
      case ({wr_en, rd_en})
        2'b10:   o_COUNT <= o_COUNT + CW'(1);
        2'b01:   o_COUNT <= o_COUNT - CW'(1);
        default: o_COUNT <= o_COUNT;
      endcase
    end
  end

  // Head register: loads the next entry after a read, or the incoming byte when it lands in an
  // empty FIFO or becomes the next head in the same cycle the old head is consumed.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      o_RD_DATA <= '0;
      o_RD_ERR  <= 1'b0;
    end else if (rd_en) begin
      if (wr_en && (rd_ptr_nxt == wr_ptr)) begin
        {o_RD_ERR, o_RD_DATA} <= wr_word;
      end else begin
        {o_RD_ERR, o_RD_DATA} <= mem[rd_ptr_nxt];
      end
    end else if (o_EMPTY && wr_en) begin
      {o_RD_ERR, o_RD_DATA} <= wr_word;
    end
  end

  // Sticky overflow and saturating drop counter; clearing wins over a same-cycle update.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      o_OVERFLOW   <= 1'b0;
      o_DROP_COUNT <= '0;
    end else if (i_CLR_FLAGS) begin
      o_OVERFLOW   <= 1'b0;
      o_DROP_COUNT <= '0;
    end else begin
      if (ovf_hit) o_OVERFLOW <= 1'b1;
      if (drop_hit && (o_DROP_COUNT != 8'hFF)) o_DROP_COUNT <= o_DROP_COUNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue scoreboard of {err, data} plus a flag model, checked every cycle.
// Latency: outputs are compared at the falling edge against the model state after the last rising edge.
// Backpressure: the consumer ready is driven per cycle by the stimulus.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          i_CLK = 1'b0;
  logic          i_RESET;
  logic          i_RX_DONE;
  logic [7:0]    i_RX_DATA;
  logic          i_FRAMING_ERROR;
  logic          i_DROP_ERRORED;
  logic          i_RD_READY;
  logic          i_CLR_FLAGS;
  logic [7:0]    o_RD_DATA;
  logic          o_RD_ERR;
  logic          o_RD_VALID;
  logic [CW-1:0] o_COUNT;
  logic          o_EMPTY;
  logic          o_FULL;
  logic          o_OVERFLOW;
  logic [7:0]    o_DROP_COUNT;

  uart_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .i_CLK          (i_CLK),
    .i_RESET        (i_RESET),
    .i_RX_DONE      (i_RX_DONE),
    .i_RX_DATA      (i_RX_DATA),
    .i_FRAMING_ERROR(i_FRAMING_ERROR),
    .i_DROP_ERRORED (i_DROP_ERRORED),
    .i_RD_READY     (i_RD_READY),
    .i_CLR_FLAGS    (i_CLR_FLAGS),
    .o_RD_DATA      (o_RD_DATA),
    .o_RD_ERR       (o_RD_ERR),
    .o_RD_VALID     (o_RD_VALID),
    .o_COUNT        (o_COUNT),
    .o_EMPTY        (o_EMPTY),
    .o_FULL         (o_FULL),
    .o_OVERFLOW     (o_OVERFLOW),
    .o_DROP_COUNT   (o_DROP_COUNT)
  );

  always #5 i_CLK = ~i_CLK;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] sb_q[$];
  logic       m_ovf;
  int         m_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every registered output against the model.
  task automatic check_outputs();
    chk("count", 32'(o_COUNT), 32'(sb_q.size()));
    chk("rd_valid", 32'(o_RD_VALID), 32'(sb_q.size() != 0));
    chk("empty", 32'(o_EMPTY), 32'(sb_q.size() == 0));
    chk("full", 32'(o_FULL), 32'(sb_q.size() == DEPTH));
    chk("overflow", 32'(o_OVERFLOW), 32'(m_ovf));
    chk("drop_count", 32'(o_DROP_COUNT), 32'(m_drop));
    if (sb_q.size() != 0) chk("head", 32'({o_RD_ERR, o_RD_DATA}), 32'(sb_q[0]));
  endtask

  // One clock: drive inputs at the falling edge, check, advance the model, take the rising edge.
  task automatic cycle(input logic done, input logic [7:0] d, input logic e,
                       input logic drop, input logic rdy, input logic clr);
    bit wr_req, rd, full;
    @(negedge i_CLK);
    i_RESET = 1'b0; i_RX_DONE = done; i_RX_DATA = d; i_FRAMING_ERROR = e;
    i_DROP_ERRORED = drop; i_RD_READY = rdy; i_CLR_FLAGS = clr;
    check_outputs();
    wr_req = done && !(drop && e);
    full   = (sb_q.size() == DEPTH);
    rd     = (sb_q.size() != 0) && rdy;
    if (rd) void'(sb_q.pop_front());
    if (wr_req && (!full || rd)) sb_q.push_back({e, d});
    if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (wr_req && full && !rd) m_ovf = 1'b1;
      if (done && drop && e && m_drop < 255) m_drop++;
    end
    @(posedge i_CLK);
  endtask

  task automatic wr(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd_one();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Reset with a concurrent write strobe, read and clear; reset must dominate all of them.
  task automatic do_reset();
    @(negedge i_CLK);
    i_RESET = 1'b1; i_RX_DONE = 1'b1; i_RX_DATA = 8'h77; i_FRAMING_ERROR = 1'b0;
    i_DROP_ERRORED = 1'b0; i_RD_READY = 1'b1; i_CLR_FLAGS = 1'b1;
    sb_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_RESET = 1'b0; i_RX_DONE = 1'b0; i_RD_READY = 1'b0; i_CLR_FLAGS = 1'b0;
  endtask

  initial begin
    i_RESET = 1'b1; i_RX_DONE = 1'b0; i_RX_DATA = '0; i_FRAMING_ERROR = 1'b0;
    i_DROP_ERRORED = 1'b0; i_RD_READY = 1'b0; i_CLR_FLAGS = 1'b0;
    sb_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    repeat (2) @(posedge i_CLK);
    @(negedge i_CLK);
    i_RESET = 1'b0;
    check_outputs();
    chk("reset_rd_data", 32'(o_RD_DATA), 32'h0);
    chk("reset_rd_err", 32'(o_RD_ERR), 32'h0);

    // Basic write then read; no fall-through on the write cycle even with ready high.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("basic_data", 32'(o_RD_DATA), 32'hA5);
    rd_one();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("basic_empty", 32'(o_EMPTY), 32'h1);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) wr(8'(i));
    wr(8'h10);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fill_overflow", 32'(o_OVERFLOW), 32'h1);
    chk("fill_count", 32'(o_COUNT), 32'd16);
    for (int i = 0; i < 16; i++) rd_one();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Simultaneous read/write at full.
    for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_rw_count", 32'(o_COUNT), 32'd16);
    chk("full_rw_ovf", 32'(o_OVERFLOW), 32'h0);
    for (int i = 0; i < 16; i++) rd_one();

    // Error tagging and drop counting with saturation.
    cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("err_tag", 32'({o_RD_ERR, o_RD_DATA}), 32'h13C);
    for (int i = 0; i < 300; i++) cycle(1'b1, 8'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_sat", 32'(o_DROP_COUNT), 32'd255);
    chk("drop_count_hold", 32'(o_COUNT), 32'd1);
    cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drop_clr", 32'(o_DROP_COUNT), 32'h0);

    // Clear beats a same-cycle overflow.
    for (int i = 0; i < 16; i++) wr(8'(8'h80 + i));
    cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_clr_prio", 32'(o_OVERFLOW), 32'h0);
    for (int i = 0; i < 16; i++) rd_one();

    // Interleaved write/read pairs across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      wr(8'(8'hC0 + i));
      rd_one();
    end

    // Random traffic including simultaneous read/write at various occupancies.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 20; i++) rd_one();

    // Reset with five entries held and a concurrent write strobe.
    for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(o_COUNT), 32'd5);
    do_reset();
    check_outputs();
    chk("rst_count", 32'(o_COUNT), 32'h0);
    chk("rst_valid", 32'(o_RD_VALID), 32'h0);
    wr(8'h42);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, SHALL be the number of entries; legal values are powers of two, 4 to 256.
REQ-002 Parameter CW, default $clog2(DEPTH)+1, SHALL be the width of o_COUNT.
REQ-003 i_CLK  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 i_RESET  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 i_RX_DONE  in  1  SHALL be the one-cycle write strobe, driven by uart_receiver o_RX_DONE.
REQ-006 i_RX_DATA  in  8  SHALL be the received byte, driven by uart_receiver o_DATA, sampled when i_RX_DONE=1.
REQ-007 i_FRAMING_ERROR  in  1  SHALL be the stop-bit error tag, driven by uart_receiver o_FRAMING_ERROR, sampled with i_RX_DATA.
REQ-008 i_DROP_ERRORED  in  1  SHALL select discard of framing-errored bytes when 1 and storage when 0.
REQ-009 i_RD_READY  in  1  SHALL be the consumer ready signal.
REQ-010 i_CLR_FLAGS  in  1  SHALL clear o_OVERFLOW and o_DROP_COUNT when 1.
REQ-011 o_RD_DATA  out  8  SHALL be the head-entry byte (show-ahead).
REQ-012 o_RD_ERR  out  1  SHALL be the head-entry framing-error tag.
REQ-013 o_RD_VALID  out  1  SHALL be high whenever the FIFO is non-empty.
REQ-014 o_COUNT  out  CW  SHALL be the occupancy, ranging 0 to DEPTH.
REQ-015 o_EMPTY / o_FULL  out  1 each  SHALL signal occupancy of 0 and DEPTH respectively.
REQ-016 o_OVERFLOW  out  1  SHALL be a sticky flag recording that a byte was lost because the FIFO was full.
REQ-017 o_DROP_COUNT  out  8  SHALL be a saturating count of bytes discarded by i_DROP_ERRORED.

Function
REQ-018 Storage SHALL be DEPTH x 9 bits {err, data}, addressed by wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-019 Write-request SHALL equal i_RX_DONE & ~(i_DROP_ERRORED & i_FRAMING_ERROR).
REQ-020 Read SHALL occur when o_RD_VALID & i_RD_READY; the read SHALL advance rd_ptr, and the next entry SHALL appear on the following cycle.
REQ-021 A write SHALL be accepted when write-request & (~o_FULL | read this cycle).
REQ-022 Latency: a byte written into an empty FIFO SHALL produce o_RD_VALID=1 with that byte on o_RD_DATA in the cycle after the i_RX_DONE edge.
REQ-023 o_RD_DATA/o_RD_ERR SHALL be a registered-memory read of rd_ptr and stable while o_RD_VALID=1 and no read occurs; when empty they SHALL be don't-care.
REQ-024 o_COUNT SHALL increment on write-only, decrement on read-only, and hold on both-or-neither.
REQ-025 Simultaneous write and read at full SHALL accept the write, with o_COUNT remaining DEPTH and o_OVERFLOW unchanged.
REQ-026 At empty, a write with i_RD_READY=1 SHALL NOT read in the same cycle (no fall-through).
REQ-027 Write-request when full with no read SHALL discard the byte, set o_OVERFLOW=1, and leave pointers and contents unchanged.
REQ-028 i_RX_DONE with i_DROP_ERRORED=1 and i_FRAMING_ERROR=1 SHALL discard the byte and increment o_DROP_COUNT, saturating at 255; this discard SHALL NOT set o_OVERFLOW.
REQ-029 i_CLR_FLAGS SHALL take priority over a same-cycle set or increment: both flags SHALL read 0 the next cycle.
REQ-030 FIFO order SHALL be strict; the stored err tag SHALL travel with its byte.

Reset
REQ-031 i_RESET=1 at a rising edge SHALL set wr_ptr=0, rd_ptr=0, o_COUNT=0, o_EMPTY=1, o_FULL=0, o_RD_VALID=0, o_OVERFLOW=0, and o_DROP_COUNT=0.
REQ-032 o_RD_DATA and o_RD_ERR SHALL be 0 after reset.
REQ-033 Reset SHALL dominate same-cycle writes, reads, and i_CLR_FLAGS.
REQ-034 Reset mid-operation SHALL discard all contents; memory array contents need not be cleared.

Verification
REQ-035 Basic: reset; pulse i_RX_DONE with data 0xA5, err=0 -> next cycle o_RD_VALID=1, o_RD_DATA=0xA5, o_RD_ERR=0, o_COUNT=1; then i_RD_READY=1 for one cycle -> o_EMPTY=1, o_COUNT=0.
REQ-036 Fill/overflow: DEPTH=16; write 0x00..0x0F, then write 0x10 with i_RD_READY=0 -> o_FULL=1, o_COUNT=16, o_OVERFLOW=1; drain reads 0x00..0x0F in order, and 0x10 never appears.
REQ-037 Full with simultaneous read/write: at full, write 0x55 with i_RD_READY=1 -> o_COUNT stays 16, o_OVERFLOW stays 0, and 0x55 emerges as the 16th read after the first.
REQ-038 Error tagging: i_DROP_ERRORED=0, write 0x3C with err=1 -> o_RD_ERR=1 with 0x3C; i_DROP_ERRORED=1, 300 errored strobes -> o_COUNT unchanged, o_DROP_COUNT=255; then i_CLR_FLAGS=1 -> o_DROP_COUNT=0.
REQ-039 Wrap and reset: 40 interleaved write/read pairs across pointer wrap -> data is in order; with o_COUNT=5, assert i_RESET concurrently with i_RX_DONE -> next cycle o_COUNT=0, o_EMPTY=1, o_RD_VALID=0.
